// File: rtl/rpsc_alarm_sequencer_if.sv
// Operator controls, raw fault inputs and lamp/interlock outputs of the
// RPSC alarm sequencer, bundled for connection between the field side
// (master) and the sequencer (slave).
interface rpsc_alarm_sequencer_if #(
   parameter int unsigned N_CH = 8
);
   logic [N_CH-1:0] fault_in;
   logic            ack_i;
   logic            op_reset_i;
   logic            lamp_test_i;
   logic [N_CH-1:0] ff_out;
   logic [N_CH-1:0] ff_la;
   logic            emergency_o;
   logic            pamp_interlock_o;
   logic [2:0]      first_out_idx;
   logic            first_out_valid;

   modport master (
      output fault_in, ack_i, op_reset_i, lamp_test_i,
      input  ff_out, ff_la, emergency_o, pamp_interlock_o,
             first_out_idx, first_out_valid
   );

   modport slave (
      input  fault_in, ack_i, op_reset_i, lamp_test_i,
      output ff_out, ff_la, emergency_o, pamp_interlock_o,
             first_out_idx, first_out_valid
   );
endinterface

// File: rtl/rpsc_alarm_sequencer.sv
// RPSC per-channel fault alarm sequencer: synchronise and debounce the raw
// fault inputs, latch them through a NORMAL/ALARM/ACKED sequence that drives
// the FF_OUT and FF_LA lamps, and aggregate into Emergency / PAMP interlock.
// Optional first-out capture and double-rate flash: `define RPSC_FIRST_OUT_EN.
module rpsc_alarm_sequencer #(
   parameter int unsigned N_CH           = 8,
   parameter int unsigned DEBOUNCE       = 16,
   parameter int unsigned FLASH_HALF     = 8,
   parameter logic [7:0]  INTERLOCK_MASK = 8'hFC
) (
   input logic                   clk,
   input logic                   reset,
   rpsc_alarm_sequencer_if.slave bus
);

   localparam logic [1:0] ST_NORMAL = 2'd0;
   localparam logic [1:0] ST_ALARM  = 2'd1;
   localparam logic [1:0] ST_ACKED  = 2'd2;

   localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [N_CH-1:0] MASK = INTERLOCK_MASK[N_CH-1:0];

   logic [N_CH-1:0]      sync1, sync2, deb;
   logic [DB_W-1:0]      db_cnt [N_CH];
   logic [N_CH-1:0][1:0] state, state_nxt;
   logic [N_CH-1:0]      out_nxt, la_nxt;
   logic [N_CH-1:0]      ff_out_r, ff_la_r;
   logic                 emergency_r, pamp_r;
   logic [FL_W-1:0]      flash_cnt;
   logic                 flash;

   // Two-flop synchroniser followed by a per-channel stability counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int unsigned i = 0; i < N_CH; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= bus.fault_in;
         sync2 <= sync1;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Free-running lamp flash, toggling every FLASH_HALF cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flash_cnt <= '0;
         flash     <= 1'b0;
      end else if (flash_cnt == FL_W'(FLASH_HALF - 1)) begin
         flash_cnt <= '0;
         flash     <= ~flash;
      end else begin
         flash_cnt <= flash_cnt + FL_W'(1);
      end
   end

`ifdef RPSC_FIRST_OUT_EN
   localparam int unsigned FAST_HALF = (FLASH_HALF / 2 > 0) ? FLASH_HALF / 2 : 1;
   localparam int unsigned FF_W      = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

   logic [FF_W-1:0] fast_cnt;
   logic            fast;
   logic            fo_valid, fo_any, all_normal_nxt;
   logic [2:0]      fo_idx, fo_pick;

   // Double-rate flash for the first-out channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fast_cnt <= '0;
         fast     <= 1'b0;
      end else if (fast_cnt == FF_W'(FAST_HALF - 1)) begin
         fast_cnt <= '0;
         fast     <= ~fast;
      end else begin
         fast_cnt <= fast_cnt + FF_W'(1);
      end
   end

   // Lowest channel entering ALARM this edge, and whether all end up NORMAL.
   always_comb begin
      fo_any         = 1'b0;
      fo_pick        = '0;
      all_normal_nxt = 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (state[i] == ST_NORMAL && deb[i] && !fo_any) begin
            fo_any  = 1'b1;
            fo_pick = 3'(i);
         end
         if (state_nxt[i] != ST_NORMAL) all_normal_nxt = 1'b0;
      end
   end

   // First-out capture holds until every channel has returned to NORMAL.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fo_valid <= 1'b0;
         fo_idx   <= '0;
      end else if (!fo_valid && fo_any) begin
         fo_valid <= 1'b1;
         fo_idx   <= fo_pick;
      end else if (all_normal_nxt) begin
         fo_valid <= 1'b0;
         fo_idx   <= '0;
      end
   end

   assign bus.first_out_idx   = fo_idx;
   assign bus.first_out_valid = fo_valid;
`else
   assign bus.first_out_idx   = '0;
   assign bus.first_out_valid = 1'b0;
`endif

   // Channel sequence transitions and the lamp/output values they imply.
   always_comb begin
      state_nxt = state;
      out_nxt   = '0;
      la_nxt    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         case (state[i])
            ST_NORMAL: if (deb[i]) state_nxt[i] = ST_ALARM;
            ST_ALARM:  if (bus.ack_i) state_nxt[i] = ST_ACKED;
            ST_ACKED:  if (bus.op_reset_i && !deb[i]) state_nxt[i] = ST_NORMAL;
            default:   state_nxt[i] = ST_NORMAL;
         endcase
         out_nxt[i] = (state[i] == ST_ALARM) || (state[i] == ST_ACKED);
`ifdef RPSC_FIRST_OUT_EN
         if (state[i] == ST_ALARM)
            la_nxt[i] = (fo_valid && fo_idx == 3'(i)) ? fast : flash;
`else
         if (state[i] == ST_ALARM) la_nxt[i] = flash;
`endif
         if (state[i] == ST_ACKED) la_nxt[i] = 1'b1;
      end
   end

   // State plus registered outputs; interlocks load from the same next value as ff_out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= '0;
         ff_out_r    <= '0;
         ff_la_r     <= '0;
         emergency_r <= 1'b0;
         pamp_r      <= 1'b0;
      end else begin
         state       <= state_nxt;
         ff_out_r    <= out_nxt;
         ff_la_r     <= la_nxt;
         emergency_r <= |out_nxt;
         pamp_r      <= |(out_nxt & MASK);
      end
   end

   assign bus.ff_out           = ff_out_r;
   assign bus.ff_la            = ff_la_r | {N_CH{bus.lamp_test_i}};
   assign bus.emergency_o      = emergency_r;
   assign bus.pamp_interlock_o = pamp_r;

endmodule

// File: doc/rpsc_alarm_sequencer.md
Name: rpsc_alarm_sequencer

Overview:
- Per-channel alarm sequencer for the eight fault flip-flop channels (FF1..FF8) on an RPSC card.
- Debounces raw fault inputs, latches faults, and runs an acknowledge/reset alarm sequence that drives the FF_OUT and FF_LA lamp outputs.
- Aggregates latched faults into the Emergency and PAMP interlock outputs, replacing the tied-off interlock on the card.
- Sits between the card's field inputs and its output and lamp drivers.

Parameters:
- N_CH, 8, number of fault channels (1..8).
- DEBOUNCE, 16, consecutive stable synchronized samples required to change a debounced input (>=1).
- FLASH_HALF, 8, half-period of the lamp flash, in clk cycles (>=1).
- INTERLOCK_MASK, 8'hFC, channels contributing to pamp_interlock_o (bit i = channel i).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- fault_in, input, N_CH, raw fault inputs, asynchronous, active-high.
- ack_i, input, 1, operator acknowledge, single-cycle pulse, synchronous.
- op_reset_i, input, 1, operator alarm reset, single-cycle pulse, synchronous.
- lamp_test_i, input, 1, lamp test, level-sensitive, synchronous.
- ff_out, output, N_CH, latched fault per channel.
- ff_la, output, N_CH, lamp drive per channel.
- emergency_o, output, 1, OR of all ff_out bits.
- pamp_interlock_o, output, 1, OR of (ff_out & INTERLOCK_MASK).
- first_out_idx, output, 3, index of the first channel to alarm.
- first_out_valid, output, 1, first_out_idx holds a valid index.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; channel FSMs in NORMAL; synchronizers, debounce counters, debounced values and flash counter cleared.
- Input path, per channel:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized value differs from the debounced value and clears when they are equal.
  - When the counter reaches DEBOUNCE-1 with the values still differing, the debounced value flips on the next edge and the counter clears.
- Latency: a clean input step produces ff_out on the rising edge DEBOUNCE+3 cycles after the first edge that samples the new input.
- Flash generator: free-running counter; the flash bit toggles every FLASH_HALF cycles and is 0 after reset.
- Channel FSM:
  - NORMAL (out=0, la=0): debounced fault=1 -> ALARM.
  - ALARM (out=1, la=flash): ack_i -> ACKED. Fault deasserting does not leave ALARM; the alarm stays latched.
  - ACKED (out=1, la=1): op_reset_i with debounced fault=0 -> NORMAL. op_reset_i with fault still 1 -> stay ACKED.
- Simultaneous events:
  - ack_i only moves channels already in ALARM before the edge. A channel entering ALARM on the same edge stays in ALARM.
  - ack_i and op_reset_i together: ack is applied first. ALARM goes to ACKED; ACKED with fault=0 goes to NORMAL.
  - ack_i in NORMAL or ACKED: no effect. op_reset_i in NORMAL or ALARM: no effect.
- lamp_test_i=1 forces ff_la to all ones combinationally. It has no effect on FSMs, ff_out, emergency_o or interlock.
- emergency_o and pamp_interlock_o are registered from the next-state ff_out, so they change on the same edge as ff_out.
- Channels >= N_CH do not exist; INTERLOCK_MASK bits >= N_CH are ignored.

Optional Feature:
- Macro: RPSC_FIRST_OUT_EN.
- Defined:
  - Captures the lowest-indexed channel entering ALARM while first_out_valid=0; sets first_out_valid and first_out_idx on that edge.
  - Later alarms do not change the capture.
  - The first-out channel in ALARM flashes at double rate, toggling every FLASH_HALF/2 cycles (minimum 1).
  - first_out_valid clears on the edge where all channels are in NORMAL.
- Undefined: first_out_idx=0 and first_out_valid=0 constantly; all ALARM lamps use the normal flash.

Test Plan:
- Reset mid-alarm: channel 2 in ALARM, then reset=0 for 1 cycle -> ff_out=0, ff_la=0, emergency_o=0 immediately, before the next clk edge.
- Debounce: DEBOUNCE=16; fault_in[0] pulse of 10 cycles -> ff_out stays 0. Held high -> ff_out[0]=1 exactly 19 cycles after the first sampling edge, emergency_o=1.
- Sequence: fault_in[3] alarms -> ff_la[3] toggles every 8 cycles. ack_i -> ff_la[3]=1. op_reset_i with fault still high -> stays ACKED. Fault removed and debounced, then op_reset_i -> ff_out[3]=0, ff_la[3]=0.
- Interlock: fault on channel 0 only -> emergency_o=1, pamp_interlock_o=0. Add channel 5 -> pamp_interlock_o=1.
- Same-edge: ack_i on the edge channel 6 enters ALARM while channel 1 is already in ALARM -> ch1 ACKED, ch6 ALARM. lamp_test_i=1 -> ff_la=8'hFF with states unchanged.
- RPSC_FIRST_OUT_EN: channels 4 and 2 enter ALARM on the same edge -> first_out_idx=2, valid=1. Then channel 1 alarms -> idx remains 2. Clear all channels -> valid=0.
